// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: lets N_CORES cores share one instruction memory with a
// combinational read port. Cores are granted in round-robin order, one at a time.
// Each grant is followed by a single FETCH cycle. The fetched word goes back to the
// granted core together with a one-cycle ack pulse. A fetch from an address at or
// above MEM_DEPTH returns END_OPCODE and sets that core's sticky fault flag.
//
// Ports:
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   core_req      per-core level request
//   core_addr     packed per-core fetch addresses (core i at [i*ADDR_W +: ADDR_W])
//   core_ack      registered one-hot-or-zero ack pulse
//   core_inst     packed per-core registered instruction words
//   core_fault    per-core sticky out-of-range flags
//   mem_read      read strobe to the instruction memory (in-range FETCH only)
//   mem_address   address to the instruction memory
//   mem_inst_in   combinational read data from the instruction memory
//   busy          high while in FETCH
module imem_fetch_arbiter #(
  parameter int unsigned N_CORES    = 4,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_DEPTH  = 100,
  parameter int unsigned END_OPCODE = 25
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CORES-1:0]          core_req,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  output logic [N_CORES-1:0]          core_ack,
  output logic [N_CORES*DATA_W-1:0]   core_inst,
  output logic [N_CORES-1:0]          core_fault,
  output logic                        mem_read,
  output logic [ADDR_W-1:0]           mem_address,
  input  logic [DATA_W-1:0]           mem_inst_in,
  output logic                        busy
);

  localparam int unsigned IdxW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e                      state_q;
  logic [IdxW-1:0]             rr_ptr_q;
  logic [IdxW-1:0]             gnt_idx_q;
  logic [ADDR_W-1:0]           addr_q;
  logic [N_CORES-1:0]          ack_q;
  logic [N_CORES*DATA_W-1:0]   inst_q;
  logic [N_CORES-1:0]          fault_q;

  logic [N_CORES-1:0]          eff_req;
  logic                        found;
  logic [IdxW-1:0]             winner;
  logic [IdxW-1:0]             rr_ptr_d;
  logic                        in_range;

  // A core that sees its ack this cycle is not re-granted in the same cycle.
  assign eff_req  = core_req & ~ack_q;
  assign in_range = (32'(addr_q) < MEM_DEPTH);

  // Cyclic first-set search starting at rr_ptr_q.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + i) % N_CORES;
      if (!found && eff_req[idx]) begin
        found  = 1'b1;
        winner = IdxW'(idx);
      end
    end
    rr_ptr_d = IdxW'((32'(winner) + 1) % N_CORES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      addr_q    <= '0;
      ack_q     <= '0;
      inst_q    <= '0;
      fault_q   <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            gnt_idx_q <= winner;
            addr_q    <= core_addr[32'(winner)*ADDR_W +: ADDR_W];
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= StFetch;
          end
        end
        StFetch: begin
          ack_q[gnt_idx_q] <= 1'b1;
          if (in_range) begin
            inst_q[32'(gnt_idx_q)*DATA_W +: DATA_W] <= mem_inst_in;
          end else begin
            inst_q[32'(gnt_idx_q)*DATA_W +: DATA_W] <= DATA_W'(END_OPCODE);
            fault_q[gnt_idx_q]                      <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory-side outputs depend only on state and the latched address.
  assign busy        = (state_q == StFetch);
  assign mem_read    = busy && in_range;
  assign mem_address = addr_q;
  assign core_ack    = ack_q;
  assign core_inst   = inst_q;
  assign core_fault  = fault_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Randomized and directed stimulus for imem_fetch_arbiter. A transaction-level
// reference model tracks the pending grant, round-robin pointer and per-core
// results. Every output is compared with it once per cycle, on the falling edge.
module tb_imem_fetch_arbiter;
  localparam int N = 4, AW = 16, DW = 16, DEPTH = 100, ENDOP = 25;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    core_req;
  logic [N*AW-1:0] core_addr;
  logic [N-1:0]    core_ack;
  logic [N*DW-1:0] core_inst;
  logic [N-1:0]    core_fault;
  logic            mem_read;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_inst_in;
  logic            busy;

  imem_fetch_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_addr  (core_addr),
    .core_ack   (core_ack),
    .core_inst  (core_inst),
    .core_fault (core_fault),
    .mem_read   (mem_read),
    .mem_address(mem_address),
    .mem_inst_in(mem_inst_in),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a * 16'd37 + 16'd11;
  endfunction

  assign mem_inst_in = mem_word(mem_address);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a grant is either pending (one fetch outstanding) or not.
  bit            m_pending;
  int            m_ptr, m_gnt;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  m_ack, m_fault;
  logic [DW-1:0] m_inst [N];

  task automatic model_reset();
    m_pending = 0; m_ptr = 0; m_gnt = 0; m_addr = '0; m_ack = '0; m_fault = '0;
    for (int i = 0; i < N; i++) m_inst[i] = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    if (m_pending) begin
      m_ack        = '0;
      m_ack[m_gnt] = 1'b1;
      if (int'(m_addr) < DEPTH) m_inst[m_gnt] = mem_word(m_addr);
      else begin
        m_inst[m_gnt]  = DW'(ENDOP);
        m_fault[m_gnt] = 1'b1;
      end
      m_pending = 0;
    end else begin
      logic [N-1:0] eff;
      eff   = core_req & ~m_ack;
      m_ack = '0;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (!m_pending && eff[c]) begin
          m_pending = 1;
          m_gnt     = c;
          m_addr    = core_addr[c*AW +: AW];
          m_ptr     = (c + 1) % N;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N*DW-1:0] exp_inst;
    for (int i = 0; i < N; i++) exp_inst[i*DW +: DW] = m_inst[i];
    check("busy", 64'(busy), 64'(m_pending));
    check("mem_read", 64'(mem_read), 64'(m_pending && int'(m_addr) < DEPTH));
    check("mem_address", 64'(mem_address), 64'(m_addr));
    check("core_ack", 64'(core_ack), 64'(m_ack));
    check("core_inst", 64'(core_inst), 64'(exp_inst));
    check("core_fault", 64'(core_fault), 64'(m_fault));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_addr(input int c, input logic [AW-1:0] a);
    core_addr[c*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  int order[$];

  initial begin
    rst       = 1'b1;
    core_req  = '0;
    core_addr = '0;
    do_reset();

    // Single core: core 2 at address 5.
    core_req = 4'b0100; set_addr(2, 16'd5);
    cycle();
    core_req = '0;
    cycle();
    cycle();

    // Simultaneous requests from cores 0 and 3 after a fresh reset.
    do_reset();
    core_req = 4'b1001; set_addr(0, 16'd0); set_addr(3, 16'd1);
    cycle(); core_req = 4'b1000;
    cycle();
    cycle(); core_req = '0;
    cycle();
    cycle();

    // Held request: core 1 at address 3, then changed to 4 after the grant.
    core_req = 4'b0010; set_addr(1, 16'd3);
    cycle(); set_addr(1, 16'd4);
    cycle();
    cycle(); core_req = '0;
    cycle();
    cycle();

    // Out of range, then an in-range fetch; the fault must stay set.
    core_req = 4'b0010; set_addr(1, 16'd100);
    cycle(); core_req = '0;
    cycle();
    core_req = 4'b0010; set_addr(1, 16'd99);
    cycle(); core_req = '0;
    cycle();
    cycle();

    // Reset mid-fetch: outputs clear at once; core 0 is granted again afterwards.
    do_reset();
    core_req = 4'b0001; set_addr(0, 16'd7);
    cycle();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    cycle();
    cycle(); core_req = '0;
    cycle();

    // Continuous load from reset: acks rotate 0,1,2,3,... one every two cycles.
    do_reset();
    core_req = '1;
    for (int i = 0; i < N; i++) set_addr(i, AW'($urandom_range(0, DEPTH - 1)));
    for (int k = 0; k < 16; k++) begin
      cycle();
      for (int i = 0; i < N; i++) if (core_ack[i]) order.push_back(i);
    end
    core_req = '0;
    check("ack_count", 64'(order.size()), 64'd8);
    foreach (order[k]) check("ack_order", 64'(order[k]), 64'(k % N));
    cycle();

    // Random traffic, including out-of-range addresses and changing addresses.
    for (int k = 0; k < 400; k++) begin
      core_req = N'($urandom);
      for (int i = 0; i < N; i++) set_addr(i, AW'($urandom_range(0, 127)));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
